// File: rtl/line_memory_pkg.sv
// Shared types and constants for the line memory block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_memory_pkg;

    localparam int LINE_W      = 256;
    localparam int ADDR_W      = 32;
    localparam int CNT_W       = 6;
    localparam int LATENCY_DEF = 10;
    localparam int DEPTH_DEF   = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_mem_array.sv
// Line storage: DEPTH x LINE_W, synchronous write, combinational read.
// Latency: write lands at the clock edge, read is same-cycle.
// Backpressure: none; the owner serialises access.
// Ports: clk_i clock; we_i write enable; addr_i line index (shared read/write);
//        wdata_i write line; rdata_o read line. Contents are never reset.
module line_mem_array
    import line_memory_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line backing store for the data cache (one request at a time).
// Latency: mem_ack_o is seen LATENCY edges after the accepting edge.
// Backpressure: requests are only taken in IDLE; enable held through ACK waits one dead cycle.
// Ports: clk_i clock; rst_i async active-low reset; mem_enable_i request valid;
//        mem_write_i 1=write-back 0=fill; mem_addr_i byte address; mem_data_i write line;
//        mem_ack_o one-cycle completion; mem_data_o last read line (held).
module line_memory
    import line_memory_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_enable_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [LINE_W-1:0] mem_data_o
);

    localparam int             IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              wr_q,    wr_d;
    logic [LINE_W-1:0] wdat_q,  wdat_d;
    logic [LINE_W-1:0] rdat_q,  rdat_d;

    logic              done;
    logic              arr_we;
    logic [LINE_W-1:0] arr_rdata;

    // Byte offset and bits above the index are dropped, so high addresses alias.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[ADDR_W-1:IDX_W+5], mem_addr_i[4:0]};

    // State register (plus request latches and read data).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
        end
    end

    // Next state. The ACK state is entered at edge accept+LATENCY-1, so the
    // pulse is captured by the requester at edge accept+LATENCY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdat_d  = wdat_q;
        unique case (state_q)
            IDLE: begin
                if (mem_enable_i) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    idx_d   = mem_addr_i[IDX_W+4:5];
                    wr_d    = mem_write_i;
                    wdat_d  = mem_data_i;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs. Array write and read capture both happen on the edge into ACK;
    // because arr_we derives from state_q, an async reset cancels a pending write.
    always_comb begin
        done      = (state_q == BUSY) && (cnt_q == CNT_LAST);
        arr_we    = done && wr_q;
        rdat_d    = (done && !wr_q) ? arr_rdata : rdat_q;
        mem_ack_o = (state_q == ACK);
    end

    assign mem_data_o = rdat_q;

    line_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .addr_i  (idx_q),
        .wdata_i (wdat_q),
        .rdata_o (arr_rdata)
    );

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory with default parameters (LATENCY=10, DEPTH=512).
// Latency: n/a.
// Backpressure: n/a.
module tb_line_memory;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         mem_enable_i;
    logic         mem_write_i;
    logic [31:0]  mem_addr_i;
    logic [255:0] mem_data_i;
    logic         mem_ack_o;
    logic [255:0] mem_data_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    line_memory dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .mem_enable_i (mem_enable_i),
        .mem_write_i  (mem_write_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .mem_ack_o    (mem_ack_o),
        .mem_data_o   (mem_data_o)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Wait for the ack pulse; k counts negedges after the accepting edge.
    task automatic wait_ack(input int k0, output int ack_k, output logic [255:0] ack_dat);
        ack_k   = -1;
        ack_dat = '0;
        for (int k = k0; k <= 40; k++) begin
            @(negedge clk_i);
            if (mem_ack_o === 1'b1) begin
                ack_k   = k;
                ack_dat = mem_data_o;
                break;
            end
        end
        mem_enable_i = 1'b0;
        @(negedge clk_i);
        check("ack_width", mem_ack_o, 1'b0);
    endtask

    // Called at a negedge with the DUT idle; enable stays high until the ack.
    task automatic req(input logic wr, input logic [31:0] addr, input logic [255:0] dat,
                       output int ack_k, output logic [255:0] ack_dat);
        mem_enable_i = 1'b1;
        mem_write_i  = wr;
        mem_addr_i   = addr;
        mem_data_i   = dat;
        @(posedge clk_i);
        wait_ack(1, ack_k, ack_dat);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] pa5, pp, pb, pc, pd, pe, po, pn, d, d2;
        int k, first, second, nacks;
        bit saw;
        pa5 = {32{8'hA5}};
        pp  = {8{32'h1234_5678}};
        pb  = {16{16'hBEEF}};
        pc  = {8{32'hC0C0_1111}};
        pd  = {8{32'hDDDD_0002}};
        pe  = {8{32'hEEEE_0003}};
        po  = {8{32'h01D0_0005}};
        pn  = {8{32'h4E40_0006}};

        rst_i = 1'b0; mem_enable_i = 1'b0; mem_write_i = 1'b0;
        mem_addr_i = '0; mem_data_i = '0;
        @(negedge clk_i);
        check("rst_ack", mem_ack_o, 1'b0);
        check("rst_data", mem_data_o, '0);
        rst_i = 1'b1;

        // First read, accepted at the first edge after reset release.
        req(1'b0, 32'h0000_0040, '0, k, d);
        check("rd40_ack_at", k, 10);

        // Write then immediate read of the same line.
        req(1'b1, 32'h0000_0100, pa5, k, d);
        check("wr100_ack_at", k, 10);
        check("wr100_data_o_unchanged", d, '0);
        req(1'b0, 32'h0000_0100, '0, k, d);
        check("rd100_ack_at", k, 10);
        check("rd100_ack_data", d, pa5);
        check("rd100_hold0", mem_data_o, pa5);
        repeat (3) @(negedge clk_i);
        check("rd100_hold3", mem_data_o, pa5);

        // A write leaves mem_data_o alone.
        req(1'b1, 32'h0000_0140, pb, k, d);
        check("wr140_ack_data", d, pa5);
        check("wr140_after", mem_data_o, pa5);

        // Aliasing: index bits [13:5] only.
        req(1'b1, 32'h0000_0020, pp, k, d);
        req(1'b0, 32'h0000_403F, '0, k, d);
        check("alias_ack_at", k, 10);
        check("alias_data", d, pp);

        // Input changes after accept are ignored.
        req(1'b1, 32'h0000_00A0, pd, k, d);
        mem_enable_i = 1'b1; mem_write_i = 1'b1;
        mem_addr_i = 32'h0000_0080; mem_data_i = pc;
        @(posedge clk_i);
        @(negedge clk_i);
        mem_addr_i = 32'h0000_00A0; mem_data_i = pe; mem_write_i = 1'b0;
        wait_ack(2, k, d);
        check("midchg_ack_at", k, 10);
        req(1'b0, 32'h0000_0080, '0, k, d);
        check("midchg_line80", d, pc);
        req(1'b0, 32'h0000_00A0, '0, k, d);
        check("midchg_lineA0", d, pd);

        // Reset in the middle of a write.
        req(1'b1, 32'h0000_0200, po, k, d);
        mem_enable_i = 1'b1; mem_write_i = 1'b1;
        mem_addr_i = 32'h0000_0200; mem_data_i = pn;
        @(posedge clk_i);
        saw = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk_i);
            mem_enable_i = 1'b0;
            if (mem_ack_o === 1'b1) saw = 1'b1;
        end
        rst_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_i);
            if (mem_ack_o === 1'b1) saw = 1'b1;
        end
        check("rstmid_no_ack", saw, 1'b0);
        check("rstmid_data_cleared", mem_data_o, '0);
        rst_i = 1'b1;
        req(1'b0, 32'h0000_0200, '0, k, d);
        check("rstmid_ack_at", k, 10);
        check("rstmid_old_data", d, po);

        // Back-to-back reads with enable held high.
        mem_enable_i = 1'b1; mem_write_i = 1'b0; mem_addr_i = 32'h0000_0100;
        @(posedge clk_i);
        first = -1; second = -1; nacks = 0; d2 = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk_i);
            if (mem_ack_o === 1'b1) begin
                nacks++;
                if (first < 0) begin
                    first = i;
                end else if (second < 0) begin
                    second = i;
                    d2 = mem_data_o;
                    mem_enable_i = 1'b0;
                end
            end
        end
        check("b2b_first_at", first, 10);
        check("b2b_second_at", second, 21);
        check("b2b_num_acks", nacks, 2);
        check("b2b_data", d2, pa5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
